// File: rtl/char_codec_defs.sv
// Shared character-codec constants, FSM encodings and helpers used by the
// number-to-ASCII converter and its ASCII-to-number decoder counterpart.
package char_codec_defs;

  localparam int unsigned NUM_W = 32;
  localparam int unsigned BCD_W = 40;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned CNT_W = 6;

  localparam logic [7:0] FC_BIN      = 8'h42;
  localparam logic [7:0] FC_DEC      = 8'h44;
  localparam logic [7:0] FC_HEX      = 8'h48;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_SKIP = 2'd2,
    ST_EMIT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FMT_BIN = 2'd0,
    FMT_HEX = 2'd1,
    FMT_DEC = 2'd2,
    FMT_BAD = 2'd3
  } fmt_e;

  // Double-dabble pre-shift correction: add 3 to every BCD digit >= 5.
  function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < int'(BCD_W / DIG_W); i++) begin
      if (r[i*DIG_W +: DIG_W] >= 4'd5) r[i*DIG_W +: DIG_W] = r[i*DIG_W +: DIG_W] + 4'd3;
    end
    return r;
  endfunction

  function automatic fmt_e decode_fc(input logic [7:0] fc);
    if (fc == FC_BIN) return FMT_BIN;
    if (fc == FC_HEX) return FMT_HEX;
    if (fc == FC_DEC || fc == 8'h00 || (fc >= 8'h30 && fc <= 8'h39)) return FMT_DEC;
    return FMT_BAD;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 32-bit binary to 10-digit BCD double-dabble, 32 cycles per
// conversion; the first shift happens on the start edge, done pulses for one cycle.
module bin2bcd_seq
  import char_codec_defs::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  logic [NUM_W-1:0] shreg;
  logic [4:0]       cnt;
  logic             busy;
  logic [BCD_W-1:0] adj_c;

  assign adj_c = dabble_adj(bcd);

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd   <= '0;
      shreg <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        bcd   <= {(BCD_W-1)'(0), bin[NUM_W-1]};
        shreg <= {bin[NUM_W-2:0], 1'b0};
        cnt   <= 5'd1;
        busy  <= 1'b1;
      end else if (busy) begin
        bcd   <= {adj_c[BCD_W-2:0], shreg[NUM_W-1]};
        shreg <= {shreg[NUM_W-2:0], 1'b0};
        cnt   <= 5'(cnt + 5'd1);
        if (cnt == 5'd31) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/num2char_stream.sv
// Streaming number-to-ASCII converter (binary/hex/decimal, MSB first, leading
// zeros suppressed). Define NUM2CHAR_SIGNED_EN for two's-complement decimal output.
module num2char_stream
  import char_codec_defs::*;
#(
  parameter bit UPPER_HEX = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NUM_W-1:0] num,
  input  logic [7:0]       fc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_char,
  output logic             out_last
);

  state_e           state;
  logic [BCD_W-1:0] dig;
  logic [CNT_W-1:0] cnt;
  logic             is_bin;
  logic             neg_pend;

  fmt_e             fmt_c;
  logic             accept_c;
  logic             neg_c;
  logic [NUM_W-1:0] mag_c;
  logic             bcd_start_c;
  logic             bcd_done;
  logic [BCD_W-1:0] bcd_val;
  logic [DIG_W-1:0] cur_c;
  logic [DIG_W-1:0] nxt_c;
  logic [BCD_W-1:0] dig_sh_c;

  assign fmt_c    = decode_fc(fc);
  assign accept_c = in_valid && in_ready && (state == ST_IDLE);

`ifdef NUM2CHAR_SIGNED_EN
  assign neg_c = (fmt_c == FMT_DEC) && num[NUM_W-1];
`else
  assign neg_c = 1'b0;
`endif

  assign mag_c       = neg_c ? NUM_W'(-num) : num;
  assign bcd_start_c = accept_c && (fmt_c == FMT_DEC);

  // Binary walks 1-bit digits, hex/decimal walk nibbles; the MSB digit is always at the top.
  assign dig_sh_c = is_bin ? {dig[BCD_W-2:0], 1'b0} : {dig[BCD_W-5:0], 4'b0};
  assign cur_c    = is_bin ? {3'b0, dig[BCD_W-1]} : dig[BCD_W-1 -: DIG_W];
  assign nxt_c    = is_bin ? {3'b0, dig_sh_c[BCD_W-1]} : dig_sh_c[BCD_W-1 -: DIG_W];

  function automatic logic [7:0] to_ascii(input logic [DIG_W-1:0] d);
    if (d < 4'd10) return ASCII_0 + 8'(d);
    return (UPPER_HEX ? 8'h37 : 8'h57) + 8'(d);
  endfunction

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (bcd_start_c),
    .bin   (mag_c),
    .done  (bcd_done),
    .bcd   (bcd_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_char  <= 8'h00;
      out_last  <= 1'b0;
      dig       <= '0;
      cnt       <= '0;
      is_bin    <= 1'b0;
      neg_pend  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (accept_c) begin
            in_ready <= 1'b0;
            neg_pend <= neg_c;
            case (fmt_c)
              FMT_BIN: begin
                is_bin <= 1'b1;
                dig    <= {num, 8'b0};
                cnt    <= CNT_W'(32);
                state  <= ST_SKIP;
              end
              FMT_HEX: begin
                is_bin <= 1'b0;
                dig    <= {num, 8'b0};
                cnt    <= CNT_W'(8);
                state  <= ST_SKIP;
              end
              FMT_DEC: begin
                is_bin <= 1'b0;
                cnt    <= CNT_W'(10);
                state  <= ST_CONV;
              end
              default: begin
                is_bin <= 1'b0;
                dig    <= '0;
                cnt    <= CNT_W'(8);
                state  <= ST_SKIP;
              end
            endcase
          end
        end
        ST_CONV: begin
          if (bcd_done) begin
            dig   <= bcd_val;
            state <= ST_SKIP;
          end
        end
        ST_SKIP: begin
          if (cur_c == '0 && cnt > CNT_W'(1)) begin
            dig <= dig_sh_c;
            cnt <= CNT_W'(cnt - CNT_W'(1));
          end else begin
            state     <= ST_EMIT;
            out_valid <= 1'b1;
            if (neg_pend) begin
              out_char <= ASCII_MINUS;
              out_last <= 1'b0;
            end else begin
              out_char <= to_ascii(cur_c);
              out_last <= (cnt == CNT_W'(1));
            end
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            if (neg_pend) begin
              // Sign has been taken; present the first digit without shifting.
              neg_pend <= 1'b0;
              out_char <= to_ascii(cur_c);
              out_last <= (cnt == CNT_W'(1));
            end else if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_char  <= 8'h00;
              in_ready  <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              dig      <= dig_sh_c;
              cnt      <= CNT_W'(cnt - CNT_W'(1));
              out_char <= to_ascii(nxt_c);
              out_last <= (cnt == CNT_W'(2));
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
